// File: rtl/seq_checker.sv
//------------------------------------------------------------------------------
// seq_checker : receive-side checker for the cyclic 2-bit Moore sequence
//               (order, dwell length, out flag; lock/wrap/error reporting)
// Revision    : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module seq_checker #(
    parameter int STEP     = 5,
    parameter int LOCK_N   = 2,
    parameter int CNT_W    = 5,
    parameter int PERIOD_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in0,
    input  logic                in1,
    input  logic                out,
    output logic [1:0]          state_o,
    output logic                locked,
    output logic                seq_err,
    output logic                tim_err,
    output logic                par_err,
    output logic                wrap,
    output logic [PERIOD_W-1:0] period_cnt,
    output logic [PERIOD_W-1:0] err_cnt
);

    localparam int               GOOD_W    = (LOCK_N < 2) ? 1 : $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0] DWELL_OK  = CNT_W'(STEP + 1);
    localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(STEP + 2);
    localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_N);

    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_TRACK  = 2'd1,
        S_LOCKED = 2'd2
    } fsm_e;

    fsm_e                fsm_q, fsm_d;
    logic [1:0]          smp_q, lst_q;
    logic                osmp_q;
    logic [CNT_W-1:0]    dwell_q, dwell_d;
    logic [GOOD_W-1:0]   good_q, good_d;
    logic [1:0]          state_q;
    logic                locked_q, seq_err_q, tim_err_q, par_err_q, wrap_q;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] err_q, err_d;

    logic w_trans, w_inc_ok, w_dwell_ok, w_checking;
    logic seq_err_d, tim_err_d, par_err_d, wrap_d, w_any_err;

    assign w_trans    = (smp_q != lst_q);
    assign w_inc_ok   = (smp_q == (lst_q + 2'd1));
    assign w_dwell_ok = (dwell_q == DWELL_OK);
    assign w_checking = (fsm_q != S_HUNT);

    // A missing transition is flagged in the cycle the dwell would pass STEP+1,
    // which is exactly when a correctly timed transition would have been seen.
    assign seq_err_d = w_checking & w_trans & ~w_inc_ok;
    assign tim_err_d = w_checking & ((w_trans & ~w_dwell_ok) | (~w_trans & w_dwell_ok));
    assign par_err_d = (osmp_q != (smp_q[1] & smp_q[0]));
    assign w_any_err = seq_err_d | tim_err_d | par_err_d;

    always_comb begin
        fsm_d  = fsm_q;
        good_d = good_q;
        wrap_d = 1'b0;
        if (w_any_err) begin
            fsm_d  = S_HUNT;
            good_d = '0;
        end else begin
            case (fsm_q)
                S_HUNT: begin
                    if (w_trans) begin
                        fsm_d  = S_TRACK;
                        good_d = '0;
                    end
                end
                S_TRACK: begin
                    // with no error raised, every transition here is a good one
                    if (w_trans) begin
                        good_d = good_q + GOOD_W'(1);
                        if ((good_q + GOOD_W'(1)) == GOOD_LOCK) begin
                            fsm_d = S_LOCKED;
                        end
                    end
                end
                S_LOCKED: begin
                    if (w_trans && (lst_q == 2'd3)) begin
                        wrap_d = 1'b1;
                    end
                end
                default: begin
                    fsm_d  = S_HUNT;
                    good_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        dwell_d = dwell_q;
        if (w_trans) begin
            dwell_d = CNT_W'(1);
        end else if (dwell_q != DWELL_MAX) begin
            dwell_d = dwell_q + CNT_W'(1);
        end
    end

    always_comb begin
        period_d = period_q;
        err_d    = err_q;
        if (wrap_d && (period_q != {PERIOD_W{1'b1}})) begin
            period_d = period_q + PERIOD_W'(1);
        end
        if (w_any_err && (err_q != {PERIOD_W{1'b1}})) begin
            err_d = err_q + PERIOD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_q     <= 2'b00;
            osmp_q    <= 1'b0;
            lst_q     <= 2'b00;
            dwell_q   <= '0;
            fsm_q     <= S_HUNT;
            good_q    <= '0;
            state_q   <= 2'b00;
            locked_q  <= 1'b0;
            seq_err_q <= 1'b0;
            tim_err_q <= 1'b0;
            par_err_q <= 1'b0;
            wrap_q    <= 1'b0;
            period_q  <= '0;
            err_q     <= '0;
        end else begin
            smp_q     <= {in0, in1};
            osmp_q    <= out;
            lst_q     <= smp_q;
            dwell_q   <= dwell_d;
            fsm_q     <= fsm_d;
            good_q    <= good_d;
            state_q   <= smp_q;
            locked_q  <= (fsm_d == S_LOCKED);
            seq_err_q <= seq_err_d;
            tim_err_q <= tim_err_d;
            par_err_q <= par_err_d;
            wrap_q    <= wrap_d;
            period_q  <= period_d;
            err_q     <= err_d;
        end
    end

    assign state_o    = state_q;
    assign locked     = locked_q;
    assign seq_err    = seq_err_q;
    assign tim_err    = tim_err_q;
    assign par_err    = par_err_q;
    assign wrap       = wrap_q;
    assign period_cnt = period_q;
    assign err_cnt    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_checker.sv
//------------------------------------------------------------------------------
// tb_seq_checker : directed bench for seq_checker with an event scoreboard
// Revision       : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_seq_checker;

    localparam logic [3:0] EV_SEQ  = 4'b1000;
    localparam logic [3:0] EV_TIM  = 4'b0100;
    localparam logic [3:0] EV_PAR  = 4'b0010;
    localparam logic [3:0] EV_WRAP = 4'b0001;

    logic       clk;
    logic       rst_n;
    logic       in0, in1, out;
    logic [1:0] state_o;
    logic       locked, seq_err, tim_err, par_err, wrap;
    logic [7:0] period_cnt, err_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int chg    = 0;

    typedef struct {
        int         cyc;
        logic [3:0] ev;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [3:0] mon_obs;

    seq_checker #(
        .STEP    (5),
        .LOCK_N  (2),
        .CNT_W   (5),
        .PERIOD_W(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0       (in0),
        .in1       (in1),
        .out       (out),
        .state_o   (state_o),
        .locked    (locked),
        .seq_err   (seq_err),
        .tim_err   (tim_err),
        .par_err   (par_err),
        .wrap      (wrap),
        .period_cnt(period_cnt),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulses are compared against the scoreboard on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            mon_obs = {seq_err, tim_err, par_err, wrap};
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                mon_e = exp_q.pop_front();
                checks++;
                assert (mon_obs === mon_e.ev) else begin
                    errors++;
                    $error("FAIL pulses@%0d observed %b expected %b", cyc, mon_obs, mon_e.ev);
                end
            end else if (mon_obs != 4'b0000) begin
                checks++;
                assert (mon_obs === 4'b0000) else begin
                    errors++;
                    $error("FAIL unexpected_pulse@%0d observed %b expected 0000", cyc, mon_obs);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_ev(input int c, input logic [3:0] ev);
        exp_t e;
        e.cyc = c;
        e.ev  = ev;
        exp_q.push_back(e);
    endtask

    task automatic set_in(input logic [1:0] s, input logic o, input logic [3:0] ev);
        in0 = s[1];
        in1 = s[0];
        out = o;
        chg = cyc;
        if (ev != 4'b0000) push_ev(cyc + 2, ev);
    endtask

    task automatic gen(input logic [1:0] s, input logic [3:0] ev);
        set_in(s, s[1] & s[0], ev);
    endtask

    // From a settled 00 in HUNT: 00 hold, 01 unchecked, 10 and 11 good -> lock
    task automatic nominal_lock();
        gen(2'd0, 4'b0); ticks(6);
        gen(2'd1, 4'b0); ticks(6);
        gen(2'd2, 4'b0); ticks(6);
        gen(2'd3, 4'b0); ticks(1);
        chk("lock_early", {31'b0, locked}, 32'd0);
        ticks(1);
        chk("lock_rise", {31'b0, locked}, 32'd1);
        chk("state_o", {30'b0, state_o}, 32'd3);
        ticks(4);
    endtask

    task automatic period();
        gen(2'd0, EV_WRAP); ticks(6);
        gen(2'd1, 4'b0);    ticks(6);
        gen(2'd2, 4'b0);    ticks(6);
        gen(2'd3, 4'b0);    ticks(6);
    endtask

    // Relock after an error that left the FSM in HUNT on state 11
    task automatic relock_from_3();
        gen(2'd0, 4'b0); ticks(6);
        gen(2'd1, 4'b0); ticks(6);
        gen(2'd2, 4'b0); ticks(1);
        chk("relock_early", {31'b0, locked}, 32'd0);
        ticks(1);
        chk("relock_rise", {31'b0, locked}, 32'd1);
        ticks(4);
        gen(2'd3, 4'b0); ticks(6);
    endtask

    initial begin
        rst_n = 1'b0;
        in0 = 1'b0; in1 = 1'b0; out = 1'b0;
        ticks(2);
        chk("rst_state_o", {30'b0, state_o}, 32'd0);
        chk("rst_flags", {27'b0, locked, seq_err, tim_err, par_err, wrap}, 32'd0);
        chk("rst_period", {24'b0, period_cnt}, 32'd0);
        chk("rst_err", {24'b0, err_cnt}, 32'd0);
        rst_n = 1'b1;

        // lock, three periods, then asynchronous reset while locked
        nominal_lock();
        repeat (3) period();
        chk("pre_rst_period", {24'b0, period_cnt}, 32'd3);
        #2;
        rst_n = 1'b0;
        in0 = 1'b0; in1 = 1'b0; out = 1'b0;
        #1;
        chk("async_rst_flags", {27'b0, locked, seq_err, tim_err, par_err, wrap}, 32'd0);
        chk("async_rst_cnts", {16'b0, period_cnt, err_cnt}, 32'd0);
        chk("async_rst_state", {30'b0, state_o}, 32'd0);
        ticks(2);
        rst_n = 1'b1;

        // nominal run: ten clean periods
        nominal_lock();
        gen(2'd0, EV_WRAP); ticks(3);
        chk("period_first", {24'b0, period_cnt}, 32'd1);
        ticks(3);
        gen(2'd1, 4'b0); ticks(6);
        gen(2'd2, 4'b0); ticks(6);
        gen(2'd3, 4'b0); ticks(6);
        repeat (9) period();
        chk("period_ten", {24'b0, period_cnt}, 32'd10);
        chk("err_none", {24'b0, err_cnt}, 32'd0);
        chk("locked_nom", {31'b0, locked}, 32'd1);

        // skip 01 -> 11
        gen(2'd0, EV_WRAP); ticks(6);
        gen(2'd1, 4'b0);    ticks(6);
        gen(2'd3, EV_SEQ);  ticks(2);
        chk("skip_locked", {31'b0, locked}, 32'd0);
        chk("skip_err", {24'b0, err_cnt}, 32'd1);
        ticks(4);
        relock_from_3();

        // short dwell on 10
        gen(2'd0, EV_WRAP); ticks(6);
        gen(2'd1, 4'b0);    ticks(6);
        gen(2'd2, 4'b0);    ticks(4);
        gen(2'd3, EV_TIM);  ticks(2);
        chk("short_locked", {31'b0, locked}, 32'd0);
        chk("short_err", {24'b0, err_cnt}, 32'd2);
        ticks(4);
        relock_from_3();

        // long dwell on 10: flagged when dwell would reach 7, late edge unchecked
        gen(2'd0, EV_WRAP); ticks(6);
        gen(2'd1, 4'b0);    ticks(6);
        gen(2'd2, 4'b0);
        push_ev(chg + 8, EV_TIM);
        ticks(7);
        gen(2'd3, 4'b0); ticks(2);
        chk("long_locked", {31'b0, locked}, 32'd0);
        chk("long_err", {24'b0, err_cnt}, 32'd3);
        ticks(4);
        gen(2'd0, 4'b0); ticks(6);
        gen(2'd1, 4'b0); ticks(2);
        chk("long_relock", {31'b0, locked}, 32'd1);
        ticks(4);
        gen(2'd2, 4'b0); ticks(6);
        gen(2'd3, 4'b0); ticks(6);

        // stuck on 10 for 20 clocks
        gen(2'd0, EV_WRAP); ticks(6);
        gen(2'd1, 4'b0);    ticks(6);
        gen(2'd2, 4'b0);
        push_ev(chg + 8, EV_TIM);
        ticks(20);
        chk("stuck_locked", {31'b0, locked}, 32'd0);
        chk("stuck_err", {24'b0, err_cnt}, 32'd4);
        gen(2'd3, 4'b0); ticks(6);
        gen(2'd0, 4'b0); ticks(6);
        gen(2'd1, 4'b0); ticks(2);
        chk("stuck_relock", {31'b0, locked}, 32'd1);
        ticks(4);
        gen(2'd2, 4'b0); ticks(6);
        gen(2'd3, 4'b0); ticks(6);

        // out flag wrong for one clock on 01; relock completes on a 3->0
        gen(2'd0, EV_WRAP); ticks(6);
        set_in(2'd1, 1'b1, EV_PAR); ticks(1);
        out = 1'b0;
        ticks(1);
        chk("par_locked", {31'b0, locked}, 32'd0);
        chk("par_err", {24'b0, err_cnt}, 32'd5);
        ticks(4);
        gen(2'd2, 4'b0); ticks(6);
        gen(2'd3, 4'b0); ticks(6);
        gen(2'd0, 4'b0); ticks(2);
        chk("lock_on_wrap", {31'b0, locked}, 32'd1);
        chk("lock_on_wrap_period", {24'b0, period_cnt}, 32'd15);
        ticks(4);
        gen(2'd1, 4'b0); ticks(6);
        gen(2'd2, 4'b0); ticks(6);
        gen(2'd3, 4'b0); ticks(6);

        // skip and bad out flag in the same cycle
        gen(2'd0, EV_WRAP); ticks(6);
        gen(2'd1, 4'b0);    ticks(6);
        set_in(2'd3, 1'b0, EV_SEQ | EV_PAR); ticks(1);
        out = 1'b1;
        ticks(1);
        chk("combo_locked", {31'b0, locked}, 32'd0);
        chk("combo_err", {24'b0, err_cnt}, 32'd6);
        ticks(4);
        relock_from_3();

        chk("final_period", {24'b0, period_cnt}, 32'd16);
        chk("final_err", {24'b0, err_cnt}, 32'd6);
        ticks(2);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_checker.md
# seq_checker

Receive-side checker for the 2-bit state sequence produced by the team's cyclic Moore sequence generator (in0/in1 state bits plus the out = in0 & in1 flag). It samples the three lines and decodes the current state. It verifies the +1 mod 4 order, the dwell length per state and the out flag, then reports lock, error pulses, wrap pulses and saturating counters. It sits on the same clock as the generator, at the far end of the in0/in1/out lines.

## Interface
- STEP, 5: generator step value; legal dwell per state is STEP+1 clocks.
- LOCK_N, 2: consecutive good transitions after the first one required to assert locked.
- CNT_W, 5: dwell counter width; must hold STEP+2.
- PERIOD_W, 8: width of period_cnt and err_cnt.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in0  in  1  state MSB from the generator.
- in1  in  1  state LSB from the generator.
- out  in  1  generator flag; must equal in0 & in1.
- state_o  out  2  last sampled state {in0,in1}.
- locked  out  1  sequence tracked and valid.
- seq_err  out  1  one-cycle pulse: transition not equal to previous+1 mod 4.
- tim_err  out  1  one-cycle pulse: dwell not equal to STEP+1 (short, long or stuck).
- par_err  out  1  one-cycle pulse: out != in0 & in1.
- wrap  out  1  one-cycle pulse on a 3->0 transition while locked.
- period_cnt  out  PERIOD_W  count of wrap pulses; saturates at all-ones.
- err_cnt  out  PERIOD_W  count of cycles with any error pulse; saturates.

## Operation
- Sample stage: smp <= {in0,in1}; osmp <= out each clock. Previous value lst <= smp. A transition is smp != lst.
- dwell counts the cycles lst has held. It loads 1 on a transition and otherwise increments, saturating at STEP+2.
- FSM states:
  - HUNT: no order or dwell check. The first transition moves to TRACK with good = 0.
  - TRACK: each good transition increments good. When good reaches LOCK_N, go to LOCKED.
  - LOCKED: keeps checking.
- A transition is good when smp == lst+1 (mod 4) and dwell == STEP+1. Any 2-bit increment is legal, including 01->10.
- Error detection in TRACK and LOCKED:
  - Bad order: seq_err.
  - Bad dwell at a transition: tim_err.
  - No transition by the time dwell would reach STEP+2: tim_err, once.
- Error detection in all states: osmp != smp[1] & smp[0] gives par_err.
- Any error sends the FSM to HUNT, clears good and deasserts locked. Checking restarts from the current sample.
- Simultaneous errors: every applicable pulse asserts in the same cycle, and err_cnt increments by exactly 1.
- wrap and the period_cnt increment occur only on a good 3->0 transition in LOCKED.
- A transition that both completes lock and is 3->0 asserts locked but no wrap.

## Timing
- Every output is registered. Reset value of every output is 0: state_o = 00, counters 0, FSM = HUNT, smp/lst = 00, dwell = 0.
- Latency: an input change at edge k is captured in smp at edge k+1. The decision is registered at edge k+2. state_o follows smp one clock later, so it updates at edge k+2.
- Pulses last exactly one clock. They are never stretched, even when errors occur on consecutive cycles.
- locked rises at the edge that registers the LOCK_N-th good transition. It falls at the edge that registers any error pulse.
- Reset mid-operation clears all state and outputs immediately (asynchronously). After release, operation begins in HUNT.

## Test plan
Use STEP=5 and LOCK_N=2.
- Nominal: drive the generator model from reset; it dwells 6 clocks per state, 00->01->10->11.
  - The 00->01 transition is unchecked.
  - 01->10 and 10->11 are good; locked rises 2 clocks after the 10->11 change.
  - The next 11->00 gives a wrap pulse and period_cnt=1, with no error pulses over 10 periods (period_cnt=10).
- Skip: while locked, drive 01 then 11 with correct dwell.
  - Required: seq_err for 1 clock, locked=0, err_cnt=1.
  - Relock occurs after 3 further good-format transitions.
- Short/long dwell: while locked, hold 10 for 4 clocks then 11 → tim_err once. Repeat with 7 clocks → tim_err once, raised when dwell would reach 7; nothing more at the late transition because the FSM is in HUNT.
- Stuck: while locked, freeze at 10 for 20 clocks.
  - Required: exactly one tim_err, err_cnt +1, locked=0.
  - The FSM stays in HUNT until the next transition.
- Out mismatch: while locked, force out=1 for one clock with state 01.
  - Required: par_err for 1 clock and locked=0.
  - Combined with a skip in the same cycle: seq_err and par_err both pulse, err_cnt +1 only.
- Reset mid-lock: assert rst_n=0 between edges while locked with period_cnt=3. All outputs read 0 immediately; after release, nominal relock as in test 1.
